// File: rtl/instr_mem_responder_if.sv
// Fetch channel between the program counter side (master) and the
// instruction-memory responder (slave): a request channel carrying the byte
// address and a response channel carrying the instruction word and fault flag.
//
// Handshake (both channels): a transfer happens on a rising clock edge where
// valid and ready are both 1. The producer must not make valid depend on ready.
// Once it raises valid, it holds valid and its payload steady until the
// transfer. ready may change on any cycle.
interface instr_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_instr;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_instr, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_instr, resp_err
    );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: accepts fetch addresses, reads a word array,
// delays the result through a fixed-latency pipeline and returns it in order
// through a small response FIFO. Credit flow control on the request side means
// the FIFO can never overflow. A side port loads the array.
// Optional build macro: IMEM_ALIGN_CHECK_EN -- when defined, an odd byte
// address is reported as a fault just like an out-of-range address.
module instr_mem_responder #(
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 2,
    parameter int RESP_DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    instr_mem_responder_if.slave     bus,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [15:0]              load_data,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW = $clog2(RESP_DEPTH) + 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(RESP_DEPTH - 1);

    // Word array; contents survive reset.
    logic [15:0] mem_q [DEPTH];

    // Request decode
    logic          accept;
    logic          range_fault;
    logic          addr_fault;
    logic [AW-1:0] rd_idx;
    logic [15:0]   rd_word;

    // Fixed-latency read pipeline, one valid bit per stage
    logic [LATENCY-1:0] stage_vld_q;
    logic [LATENCY-1:0] stage_err_q;
    logic [15:0]        stage_data_q [LATENCY];

    // Response FIFO
    logic [15:0]           fifo_data_q [RESP_DEPTH];
    logic [RESP_DEPTH-1:0] fifo_err_q;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         fifo_count_q, fifo_count_d;
    logic [CW-1:0]         in_flight_q, in_flight_d;
    logic [CW:0]           credits_used;
    logic                  push;
    logic                  pop;
    logic                  fifo_empty;

    assign accept      = bus.req_valid & bus.req_ready;
    assign rd_idx      = bus.req_addr[AW:1];
    assign range_fault = (32'(bus.req_addr[15:1]) >= 32'(DEPTH));

`ifdef IMEM_ALIGN_CHECK_EN
    assign addr_fault = range_fault | bus.req_addr[0];
`else
    // Byte-lane bit carries no meaning for 16-bit fetches in this build.
    logic unused_addr_lsb;
    assign unused_addr_lsb = bus.req_addr[0];
    assign addr_fault      = range_fault;
`endif

    // A faulting fetch returns a zero word rather than aliased array data.
    assign rd_word = addr_fault ? 16'h0000 : mem_q[rd_idx];

    // Load port write; a fetch accepted on the same edge still sees the old word.
    always_ff @(posedge clock) begin
        if (load_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // Capture the read at the accept edge and shift it down the pipeline.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stage_vld_q <= '0;
            stage_err_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stage_data_q[i] <= '0;
            end
        end else begin
            stage_vld_q[0]  <= accept;
            stage_err_q[0]  <= addr_fault;
            stage_data_q[0] <= rd_word;
            for (int i = 1; i < LATENCY; i++) begin
                stage_vld_q[i]  <= stage_vld_q[i-1];
                stage_err_q[i]  <= stage_err_q[i-1];
                stage_data_q[i] <= stage_data_q[i-1];
            end
        end
    end

    assign push       = stage_vld_q[LATENCY-1];
    assign fifo_empty = (fifo_count_q == '0);
    assign pop        = ~fifo_empty & bus.resp_ready;

    // FIFO storage; only entries between the pointers are ever observed.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= stage_data_q[LATENCY-1];
            fifo_err_q[wr_ptr_q]  <= stage_err_q[LATENCY-1];
        end
    end

    // Next-state for pointers and the two credit counters.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        in_flight_d  = in_flight_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            fifo_count_d = fifo_count_q + CW'(1);
        end else if (pop && !push) begin
            fifo_count_d = fifo_count_q - CW'(1);
        end
        if (accept && !push) begin
            in_flight_d = in_flight_q + CW'(1);
        end else if (push && !accept) begin
            in_flight_d = in_flight_q - CW'(1);
        end
    end

    // Pointer and counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            in_flight_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            in_flight_q  <= in_flight_d;
        end
    end

    // Every accepted request owns a FIFO slot from acceptance until its pop,
    // so ready comes from registered counts only.
    assign credits_used  = {1'b0, in_flight_q} + {1'b0, fifo_count_q};
    assign bus.req_ready = (credits_used < (CW+1)'(RESP_DEPTH));

    assign bus.resp_valid = ~fifo_empty;
    assign bus.resp_instr = fifo_empty ? 16'h0000 : fifo_data_q[rd_ptr_q];
    assign bus.resp_err   = fifo_empty ? 1'b0     : fifo_err_q[rd_ptr_q];
    assign busy           = (|stage_vld_q) | ~fifo_empty;
endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: vector table, hand sequences for latency,
// backpressure, range fault, load collision and mid-run reset, plus a random
// phase. Responses are checked against an expected queue.
module tb_instr_mem_responder;
  localparam int DEPTH      = 256;
  localparam int LATENCY    = 2;
  localparam int RESP_DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  instr_mem_responder_if bus();
  logic        load_en;
  logic [7:0]  load_addr;
  logic [15:0] load_data;
  logic        busy;

  instr_mem_responder #(
    .DEPTH(DEPTH), .LATENCY(LATENCY), .RESP_DEPTH(RESP_DEPTH)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .busy      (busy)
  );

  // ---------------- scoreboard state ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [16:0] exp_q[$];
  logic [15:0] model_mem [DEPTH];

  typedef struct {
    logic [15:0] addr;
    logic [15:0] exp_instr;
    logic        exp_err;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] model_resp(input logic [15:0] a);
    logic fault;
    fault = (a[15:1] >= 15'(DEPTH));
`ifdef IMEM_ALIGN_CHECK_EN
    fault = fault | a[0];
`endif
    return fault ? {1'b1, 16'h0000} : {1'b0, model_mem[a[8:1]]};
  endfunction

  // Response monitor: pops the expected queue on every handshake.
  always @(negedge clock) begin
    logic [16:0] e;
    if (reset_n && bus.resp_valid && bus.resp_ready) begin
      check("resp_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("resp_word", {15'd0, bus.resp_err, bus.resp_instr}, {15'd0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [7:0] idx, input logic [15:0] data);
    load_en   = 1'b1;
    load_addr = idx;
    load_data = data;
    tick();
    model_mem[idx] = data;
    load_en = 1'b0;
  endtask

  // Leaves req_valid high so calls can run back to back.
  task automatic send_req(input logic [15:0] addr, input logic [16:0] exp);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    while (!bus.req_ready && n < 200) begin
      tick();
      n++;
    end
    check("req_accept_timeout", 32'(bus.req_ready), 1);
    if (bus.req_ready) exp_q.push_back(exp);
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    check("drain_done", 32'(exp_q.size() != 0 || busy), 0);
  endtask

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int acc;
    logic accepted_now;
    logic [15:0] held;

    bus.req_valid  = 1'b0;
    bus.req_addr   = 16'h0000;
    bus.resp_ready = 1'b0;
    load_en        = 1'b0;
    load_addr      = '0;
    load_data      = '0;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    check("rst_resp_valid", 32'(bus.resp_valid), 0);
    check("rst_resp_instr", 32'(bus.resp_instr), 0);
    check("rst_resp_err",   32'(bus.resp_err), 0);
    check("rst_busy",       32'(busy), 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("rst_req_ready", 32'(bus.req_ready), 1);

    // Preload pattern: word i = {i, ~i}
    for (int i = 0; i < DEPTH; i++) begin
      load_word(8'(i), {8'(i), ~8'(i)});
    end

    // Vector table
    vecs[0] = '{16'h0000, 16'h00FF, 1'b0};
    vecs[1] = '{16'h0002, 16'h01FE, 1'b0};
    vecs[2] = '{16'h00FE, 16'h7F80, 1'b0};
    vecs[3] = '{16'h01FE, 16'hFF00, 1'b0};
    vecs[4] = '{16'h0200, 16'h0000, 1'b1};
    vecs[5] = '{16'h0100, 16'h807F, 1'b0};
    vecs[6] = '{16'hFFFE, 16'h0000, 1'b1};
    vecs[7] = '{16'h0201, 16'h0000, 1'b1};
`ifdef IMEM_ALIGN_CHECK_EN
    vecs[8] = '{16'h0007, 16'h0000, 1'b1};
    vecs[9] = '{16'h0001, 16'h0000, 1'b1};
`else
    vecs[8] = '{16'h0007, 16'h03FC, 1'b0};
    vecs[9] = '{16'h0001, 16'h00FF, 1'b0};
`endif
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_req(vecs[i].addr, {vecs[i].exp_err, vecs[i].exp_instr});
    end
    drain();

    // Latency: word 3 = A5C3, fetch 0x0006
    load_word(8'd3, 16'hA5C3);
    bus.resp_ready = 1'b1;
    bus.req_addr   = 16'h0006;
    bus.req_valid  = 1'b1;
    check("lat_req_ready", 32'(bus.req_ready), 1);
    exp_q.push_back({1'b0, 16'hA5C3});
    tick();
    bus.req_valid = 1'b0;
    check("lat_busy_after_accept", 32'(busy), 1);
    for (int i = 0; i < LATENCY; i++) begin
      check("lat_not_early", 32'(bus.resp_valid), 0);
      tick();
    end
    check("lat_resp_valid", 32'(bus.resp_valid), 1);
    check("lat_resp_instr", 32'(bus.resp_instr), 32'h0000_A5C3);
    check("lat_resp_err",   32'(bus.resp_err), 0);
    tick();
    check("lat_busy_after_pop", 32'(busy), 0);
    check("lat_valid_after_pop", 32'(bus.resp_valid), 0);

    // Backpressure: exactly RESP_DEPTH accepted while resp_ready=0
    bus.resp_ready = 1'b0;
    bus.req_addr   = 16'h0000;
    bus.req_valid  = 1'b1;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.req_ready) begin
        exp_q.push_back(model_resp(bus.req_addr));
        acc++;
        tick();
        bus.req_addr = bus.req_addr + 16'd2;
      end else begin
        tick();
      end
    end
    check("bp_accepted", 32'(acc), RESP_DEPTH);
    check("bp_req_ready_low", 32'(bus.req_ready), 0);
    check("bp_resp_valid", 32'(bus.resp_valid), 1);
    held = bus.resp_instr;
    tick();
    check("bp_hold_instr", 32'(bus.resp_instr), 32'(held));
    check("bp_hold_first", 32'(bus.resp_instr), 32'h0000_00FF);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    tick();
    check("bp_ready_after_pop", 32'(bus.req_ready), 1);
    drain();

    // Range fault followed by an in-range fetch
    send_req(16'h0200, {1'b1, 16'h0000});
    send_req(16'h0010, {1'b0, model_mem[8]});
    drain();

    // Load collision on word 5
    load_word(8'd5, 16'hFFFF);
    load_en       = 1'b1;
    load_addr     = 8'd5;
    load_data     = 16'h1234;
    bus.req_addr  = 16'h000A;
    bus.req_valid = 1'b1;
    check("coll_req_ready", 32'(bus.req_ready), 1);
    exp_q.push_back({1'b0, 16'hFFFF});
    tick();
    model_mem[5]  = 16'h1234;
    load_en       = 1'b0;
    bus.req_valid = 1'b0;
    send_req(16'h000A, {1'b0, 16'h1234});
    drain();

    // Random traffic with random backpressure and concurrent loads
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'($urandom_range(0, 16'h03FF));
    acc = 0;
    for (int c = 0; c < 2000 && acc < 40; c++) begin
      bus.resp_ready = 1'($urandom_range(0, 1));
      load_en   = ($urandom_range(0, 3) == 0);
      load_addr = 8'($urandom_range(0, DEPTH - 1));
      load_data = 16'($urandom);
      accepted_now = bus.req_ready;
      if (accepted_now) begin
        exp_q.push_back(model_resp(bus.req_addr));
        acc++;
      end
      tick();
      if (load_en) model_mem[load_addr] = load_data;
      if (accepted_now) bus.req_addr = 16'($urandom_range(0, 16'h03FF));
    end
    load_en = 1'b0;
    check("rand_accepted", 32'(acc), 40);
    drain();

    // Reset with responses queued
    bus.resp_ready = 1'b0;
    send_req(16'h0020, model_resp(16'h0020));
    send_req(16'h0022, model_resp(16'h0022));
    send_req(16'h0024, model_resp(16'h0024));
    bus.req_valid = 1'b0;
    tick(); tick(); tick();
    check("mid_resp_valid_before", 32'(bus.resp_valid), 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_resp_valid", 32'(bus.resp_valid), 0);
    check("mid_rst_busy",       32'(busy), 0);
    check("mid_rst_resp_instr", 32'(bus.resp_instr), 0);
    check("mid_rst_resp_err",   32'(bus.resp_err), 0);
    exp_q.delete();
    tick(); tick();
    reset_n = 1'b1;
    #1;
    check("mid_rst_req_ready", 32'(bus.req_ready), 1);
    tick();
    check("mid_rst_no_stale", 32'(bus.resp_valid), 0);
    bus.resp_ready = 1'b1;
    send_req(16'h0006, {1'b0, 16'hA5C3});
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
